// File: rtl/ltc2324_serial_rx.sv
// CNV/SCK sequencer and four-lane MSB-first serial capture for an LTC2324-16 ADC.
// Define LTC2324_CLKOUT_EN to capture on the ADC's echoed CLKOUT through 2-FF synchronisers.
module ltc2324_serial_rx #(
  parameter int unsigned T_CNV_HIGH = 2,
  parameter int unsigned T_CONV     = 30,
  parameter int unsigned SCK_HALF   = 2
) (
  input  logic        adc_clk,
  input  logic        adc_rst_n,
  input  logic        sample_en,
  output logic        CNV,
  output logic        SCK,
  input  logic        CLKOUT,
  input  logic        SDO1,
  input  logic        SDO2,
  input  logic        SDO3,
  input  logic        SDO4,
  output logic        valid,
  output logic [15:0] ch1,
  output logic [15:0] ch2,
  output logic [15:0] ch3,
  output logic [15:0] ch4,
  output logic        busy,
  output logic        frame_err
);

  localparam int unsigned CNT_W  = 10;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned N_CH   = 4;
  localparam int unsigned PH_W   = 5;
  localparam int unsigned BIT_W  = 4;

  typedef enum logic [2:0] {S_IDLE, S_CNV, S_CONV, S_SHIFT, S_DONE} state_t;

  state_t                      r_state, w_state_nxt;
  logic [CNT_W-1:0]            r_cnt, w_cnt_nxt;
  logic [PH_W-1:0]             r_phase, w_phase_nxt;
  logic [BIT_W-1:0]            r_bit_cnt, w_bit_cnt_nxt;
  logic                        r_all_bits, w_all_bits_nxt;
  logic                        r_sck_stop, w_sck_stop_nxt;
  logic [N_CH-1:0][DATA_W-1:0] r_sreg, w_sreg_nxt;
  logic [N_CH-1:0][DATA_W-1:0] r_ch, w_ch_nxt;
  logic                        r_cnv, r_sck, r_valid, r_busy;
  logic                        w_sck_nxt, w_cap, w_done_nxt;
  logic [N_CH-1:0]             w_sdo;

`ifdef LTC2324_CLKOUT_EN
  localparam int unsigned TMO_CYC = 8;

  logic [2:0]      r_clk_sync;
  logic [N_CH-1:0] r_sdo_s1, r_sdo_s2;
  logic            r_ferr;
  logic            w_clk_rise;

  // CLKOUT and SDO lanes share the same two-stage latency so data stays aligned to its edge
  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_clk_sync <= '0;
      r_sdo_s1   <= '0;
      r_sdo_s2   <= '0;
      r_ferr     <= 1'b0;
    end else begin
      r_clk_sync <= {r_clk_sync[1:0], CLKOUT};
      r_sdo_s1   <= {SDO4, SDO3, SDO2, SDO1};
      r_sdo_s2   <= r_sdo_s1;
      r_ferr     <= w_done_nxt && !r_all_bits;
    end
  end

  assign w_clk_rise = r_clk_sync[1] && !r_clk_sync[2];
  assign w_sdo      = r_sdo_s2;
  assign frame_err  = r_ferr;
`else
  logic w_unused_clkout;

  assign w_unused_clkout = CLKOUT;
  assign w_sdo           = {SDO4, SDO3, SDO2, SDO1};
  assign frame_err       = 1'b0;
`endif

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) r_state <= S_IDLE;
    else            r_state <= w_state_nxt;
  end

  // Next-state, frame timing and capture; every output register is loaded from next-state values
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_phase_nxt    = r_phase;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_all_bits_nxt = r_all_bits;
    w_sck_stop_nxt = r_sck_stop;
    w_sreg_nxt     = r_sreg;
    w_ch_nxt       = r_ch;

    unique case (r_state)
      S_IDLE: begin
        if (sample_en) begin
          w_state_nxt = S_CNV;
          w_cnt_nxt   = '0;
        end
      end
      S_CNV: begin
        w_phase_nxt    = '0;
        w_bit_cnt_nxt  = '0;
        w_all_bits_nxt = 1'b0;
        w_sck_stop_nxt = 1'b0;
        if (r_cnt == CNT_W'(T_CNV_HIGH - 1)) begin
          w_state_nxt = S_CONV;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_CONV: begin
        if (r_cnt == CNT_W'(T_CONV - 1)) begin
          w_state_nxt = S_SHIFT;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // Even half-periods are SCK high, so the first rise lands on entry to S_SHIFT
        if (!r_sck_stop) begin
          if (r_cnt == CNT_W'(SCK_HALF - 1)) begin
            w_cnt_nxt = '0;
            if (r_phase == PH_W'(31)) begin
`ifdef LTC2324_CLKOUT_EN
              w_sck_stop_nxt = 1'b1;
`else
              w_state_nxt = S_DONE;
`endif
            end else begin
              w_phase_nxt = r_phase + PH_W'(1);
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
`ifdef LTC2324_CLKOUT_EN
        else if (r_all_bits || (r_cnt == CNT_W'(TMO_CYC - 1))) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end
      S_DONE: begin
        w_state_nxt = sample_en ? S_CNV : S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase

    w_sck_nxt = (w_state_nxt == S_SHIFT) && !w_sck_stop_nxt && !w_phase_nxt[0];

`ifdef LTC2324_CLKOUT_EN
    w_cap = (r_state == S_SHIFT) && w_clk_rise && !r_all_bits;
`else
    w_cap = w_sck_nxt && !r_sck;
`endif

    if (w_cap) begin
      w_sreg_nxt[0] = {r_sreg[0][DATA_W-2:0], w_sdo[0]};
      w_sreg_nxt[1] = {r_sreg[1][DATA_W-2:0], w_sdo[1]};
      w_sreg_nxt[2] = {r_sreg[2][DATA_W-2:0], w_sdo[2]};
      w_sreg_nxt[3] = {r_sreg[3][DATA_W-2:0], w_sdo[3]};
      w_bit_cnt_nxt = r_bit_cnt + BIT_W'(1);
      if (r_bit_cnt == BIT_W'(15)) w_all_bits_nxt = 1'b1;
    end

    w_done_nxt = (w_state_nxt == S_DONE);
    if (w_done_nxt && r_all_bits) w_ch_nxt = r_sreg;
  end

  always_ff @(posedge adc_clk or negedge adc_rst_n) begin
    if (!adc_rst_n) begin
      r_cnt      <= '0;
      r_phase    <= '0;
      r_bit_cnt  <= '0;
      r_all_bits <= 1'b0;
      r_sck_stop <= 1'b0;
      r_sreg     <= '0;
      r_ch       <= '0;
      r_cnv      <= 1'b0;
      r_sck      <= 1'b0;
      r_valid    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_phase    <= w_phase_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_all_bits <= w_all_bits_nxt;
      r_sck_stop <= w_sck_stop_nxt;
      r_sreg     <= w_sreg_nxt;
      r_ch       <= w_ch_nxt;
      r_cnv      <= (w_state_nxt == S_CNV);
      r_sck      <= w_sck_nxt;
      r_valid    <= w_done_nxt && r_all_bits;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  assign CNV   = r_cnv;
  assign SCK   = r_sck;
  assign valid = r_valid;
  assign busy  = r_busy;
  assign ch1   = r_ch[0];
  assign ch2   = r_ch[1];
  assign ch3   = r_ch[2];
  assign ch4   = r_ch[3];

endmodule

// File: tb/tb_ltc2324_serial_rx.sv
// Directed bench for ltc2324_serial_rx (default build): frame timing, data capture,
// continuous conversion, mid-frame sample_en drop and mid-frame reset.
module tb_ltc2324_serial_rx;

  logic        adc_clk = 1'b0;
  logic        adc_rst_n;
  logic        sample_en;
  logic        CNV, SCK, CLKOUT;
  logic        SDO1, SDO2, SDO3, SDO4;
  logic        valid, busy, frame_err;
  logic [15:0] ch1, ch2, ch3, ch4;

  always #5 adc_clk = ~adc_clk;

  ltc2324_serial_rx dut (
    .adc_clk   (adc_clk),
    .adc_rst_n (adc_rst_n),
    .sample_en (sample_en),
    .CNV       (CNV),
    .SCK       (SCK),
    .CLKOUT    (CLKOUT),
    .SDO1      (SDO1),
    .SDO2      (SDO2),
    .SDO3      (SDO3),
    .SDO4      (SDO4),
    .valid     (valid),
    .ch1       (ch1),
    .ch2       (ch2),
    .ch3       (ch3),
    .ch4       (ch4),
    .busy      (busy),
    .frame_err (frame_err)
  );

  // ADC model: loads the frame word when CNV falls, presents MSB, shifts on each SCK fall
  logic [63:0] adc_word;
  logic [15:0] sh1 = '0, sh2 = '0, sh3 = '0, sh4 = '0;
  logic        cnv_q = 1'b0, sck_q = 1'b0;
  logic [2:0]  ck_dly = '0;

  always @(negedge adc_clk) begin
    if (cnv_q && !CNV) begin
      sh1 <= adc_word[63:48];
      sh2 <= adc_word[47:32];
      sh3 <= adc_word[31:16];
      sh4 <= adc_word[15:0];
    end else if (sck_q && !SCK) begin
      sh1 <= {sh1[14:0], 1'b0};
      sh2 <= {sh2[14:0], 1'b0};
      sh3 <= {sh3[14:0], 1'b0};
      sh4 <= {sh4[14:0], 1'b0};
    end
    cnv_q  <= CNV;
    sck_q  <= SCK;
    ck_dly <= {ck_dly[1:0], SCK};
  end

  assign SDO1   = sh1[15];
  assign SDO2   = sh2[15];
  assign SDO3   = sh3[15];
  assign SDO4   = sh4[15];
  assign CLKOUT = ck_dly[2];

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge adc_clk);
    #1;
    cyc++;
  endtask

  initial begin
    logic [63:0] pat [5];
    int t0, cnv_rise, cnv_fall, sck_rise1, sck_f1, cnv_f1, rises, n_valid;
    int busy_low, ferr_cnt, v3, cnv_hi, guard;
    int vcyc [3];
    logic prev_cnv, prev_sck;

    pat[0] = {16'hA5C3, 16'h0001, 16'h8000, 16'hFFFF};
    pat[1] = {16'h1234, 16'hFFFE, 16'h7FFF, 16'h0000};
    pat[2] = {16'hDEAD, 16'hBEEF, 16'h5A5A, 16'h0F0F};
    pat[3] = {16'hC3A5, 16'h8001, 16'h0180, 16'hF00F};
    pat[4] = {16'h1111, 16'h2222, 16'h3333, 16'h4444};

    // Reset state
    adc_rst_n = 1'b0;
    sample_en = 1'b0;
    adc_word  = pat[0];
    repeat (3) tick();
    check("rst_cnv",   64'(CNV),   64'd0);
    check("rst_sck",   64'(SCK),   64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy",  64'(busy),  64'd0);
    check("rst_ferr",  64'(frame_err), 64'd0);
    check("rst_ch",    {ch1, ch2, ch3, ch4}, 64'd0);

    // Three back-to-back frames with sample_en held high
    adc_rst_n = 1'b1;
    tick();
    sample_en = 1'b1;
    t0 = cyc;
    cnv_rise = -1; cnv_fall = -1; sck_rise1 = -1;
    sck_f1 = 0; cnv_f1 = 0; rises = 0; n_valid = 0; busy_low = 0; ferr_cnt = 0;
    vcyc[0] = -1000; vcyc[1] = -1000; vcyc[2] = -1000;
    prev_cnv = CNV; prev_sck = SCK;
    for (int c = 0; c < 300; c++) begin
      tick();
      if (CNV && !prev_cnv && cnv_rise < 0) cnv_rise = cyc;
      if (!CNV && prev_cnv && cnv_fall < 0) cnv_fall = cyc;
      if (CNV && n_valid == 0) cnv_f1++;
      if (SCK && !prev_sck) begin
        if (sck_rise1 < 0) sck_rise1 = cyc;
        if (n_valid == 0) sck_f1++;
        rises++;
      end
      if (!busy) busy_low++;
      if (frame_err) ferr_cnt++;
      if (valid) begin
        if (n_valid < 3) begin
          vcyc[n_valid] = cyc;
          check($sformatf("frame%0d_data", n_valid), {ch1, ch2, ch3, ch4}, pat[n_valid]);
          adc_word = pat[n_valid + 1];
        end
        n_valid++;
      end
      prev_cnv = CNV;
      prev_sck = SCK;
    end
    check("cnv_start_latency", 64'(cnv_rise - t0), 64'd1);
    check("cnv_high_cycles",   64'(cnv_f1), 64'd2);
    check("cnv_fall_to_sck",   64'(sck_rise1 - cnv_fall), 64'd30);
    check("sck_pulses_frame1", 64'(sck_f1), 64'd16);
    check("sck_pulses_total",  64'(rises), 64'd48);
    check("valid_count",       64'(n_valid), 64'd3);
    check("valid0_latency",    64'(vcyc[0] - t0), 64'd97);
    check("frame_period_1",    64'(vcyc[1] - vcyc[0]), 64'd97);
    check("frame_period_2",    64'(vcyc[2] - vcyc[1]), 64'd97);
    check("busy_never_low",    64'(busy_low), 64'd0);
    check("frame_err_quiet",   64'(ferr_cnt), 64'd0);
    check("ch_hold_frame3",    {ch1, ch2, ch3, ch4}, pat[2]);

    // sample_en dropped while frame 4 is in S_CONV: frame completes, then idle
    sample_en = 1'b0;
    n_valid = 0; v3 = -1000; cnv_hi = 0;
    for (int c = 0; c < 150; c++) begin
      tick();
      if (CNV) cnv_hi++;
      if (valid) begin
        if (n_valid == 0) v3 = cyc;
        n_valid++;
      end
    end
    check("drop_valid_count", 64'(n_valid), 64'd1);
    check("drop_valid_time",  64'(v3 - t0), 64'd388);
    check("drop_cnv_low",     64'(cnv_hi), 64'd0);
    check("drop_busy",        64'(busy), 64'd0);
    check("drop_ch_hold",     {ch1, ch2, ch3, ch4}, pat[3]);

    // Reset pulsed during the 8th SCK pulse
    adc_word  = pat[4];
    sample_en = 1'b1;
    rises = 0; n_valid = 0; guard = 0;
    prev_sck = SCK;
    while (rises < 8 && guard < 200) begin
      tick();
      guard++;
      if (SCK && !prev_sck) rises++;
      if (valid) n_valid++;
      prev_sck = SCK;
    end
    check("mid_rst_reached_8th", 64'(rises), 64'd8);
    adc_rst_n = 1'b0;
    #1;
    check("mid_rst_cnv",   64'(CNV),   64'd0);
    check("mid_rst_sck",   64'(SCK),   64'd0);
    check("mid_rst_busy",  64'(busy),  64'd0);
    check("mid_rst_valid", 64'(valid), 64'd0);
    check("mid_rst_ch",    {ch1, ch2, ch3, ch4}, 64'd0);
    tick();
    tick();
    check("in_rst_busy", 64'(busy), 64'd0);
    sample_en = 1'b0;
    adc_rst_n = 1'b1;
    cnv_hi = 0;
    for (int c = 0; c < 120; c++) begin
      tick();
      if (valid) n_valid++;
      if (CNV) cnv_hi++;
    end
    check("post_rst_no_valid", 64'(n_valid), 64'd0);
    check("post_rst_no_cnv",   64'(cnv_hi), 64'd0);
    check("post_rst_ch",       {ch1, ch2, ch3, ch4}, 64'd0);
    check("post_rst_busy",     64'(busy), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
